// File: rtl/burst_pkg.sv
// ============================================================================
// Module : burst_pkg
// Brief  : Shared FSM state type and default widths for burst_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package burst_pkg;

   localparam int C_ADDR_WIDTH = 16;
   localparam int C_DATA_WIDTH = 8;
   localparam int C_LEN_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/burst_ctrl.sv
// ============================================================================
// Module : burst_ctrl
// Brief  : Incrementing-address burst controller for a registered-read SRAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module burst_ctrl
   import burst_pkg::*;
#(
   parameter int ADDR_WIDTH = C_ADDR_WIDTH,
   parameter int DATA_WIDTH = C_DATA_WIDTH,
   parameter int LEN_WIDTH  = C_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_wren,
   output logic                  mem_rden,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic                  r_rvalid;
   logic                  r_done;
   logic                  w_beat;
   logic                  w_last;

   // A beat is one memory command issued this cycle; the counter holds beats-1.
   assign w_beat = ((r_state == WR) && wdata_valid) || (r_state == RD);
   assign w_last = w_beat && (r_cnt == '0);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_next_state = req_write ? WR : RD;
            end
         end
         WR, RD: begin
            if (w_last) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_cnt    <= '0;
         r_rvalid <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == IDLE) && req_valid) begin
            r_addr <= req_addr;
            r_cnt  <= req_len;
         end else if (w_beat) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_cnt  <= r_cnt - LEN_WIDTH'(1);
         end
         r_rvalid <= (r_state == RD);
         r_done   <= w_last;
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign wdata_ready = (r_state == WR);
   assign mem_wren    = (r_state == WR) && wdata_valid;
   assign mem_rden    = (r_state == RD);
   assign mem_addr    = r_addr;
   assign mem_wdata   = wdata;
   assign rdata_valid = r_rvalid;
   assign rdata       = mem_rdata;
   assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_burst_ctrl.sv
// ============================================================================
// Module : tb_burst_ctrl
// Brief  : Directed and randomized checks of burst_ctrl against a beat model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_burst_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_len = '0;
   logic        wdata_valid = 1'b0;
   logic        wdata_ready;
   logic [7:0]  wdata = '0;
   logic        rdata_valid;
   logic [7:0]  rdata;
   logic        busy;
   logic        done;
   logic        mem_wren;
   logic        mem_rden;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   burst_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata),
      .busy(busy), .done(done),
      .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered-read SRAM attached to the mem_* port, plus the model's own copy.
   logic [7:0] sram    [0:65535];
   logic [7:0] exp_mem [0:65535];
   logic       sram_init = 1'b0;
   logic       exp_init = 1'b0;

   always @(posedge clk) begin
      if (!sram_init) begin
         for (int i = 0; i < 65536; i++) sram[i] <= 8'(i * 7 + 3);
         sram_init <= 1'b1;
      end else begin
         if (mem_wren) sram[mem_addr] <= mem_wdata;
         if (mem_rden) mem_rdata <= sram[mem_addr];
      end
   end

   // Beat-level model: mode (0 idle, 1 write, 2 read), next address, beats left.
   int          m_mode = 0;
   logic [15:0] m_addr = '0;
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic        m_rv = 1'b0;
   logic [7:0]  m_rexp = '0;
   logic        m_beat;

   assign m_beat = ((m_mode == 1) && wdata_valid) || (m_mode == 2);

   always @(posedge clk) begin
      if (!exp_init) begin
         for (int i = 0; i < 65536; i++) exp_mem[i] <= 8'(i * 7 + 3);
         exp_init <= 1'b1;
      end else if (rstn && (m_mode == 1) && wdata_valid) begin
         exp_mem[m_addr] <= wdata;
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_mode <= 0;
         m_addr <= '0;
         m_left <= 0;
         m_done <= 1'b0;
         m_rv   <= 1'b0;
         m_rexp <= '0;
      end else begin
         m_done <= m_beat && (m_left == 1);
         m_rv   <= (m_mode == 2);
         m_rexp <= exp_mem[m_addr];
         if (m_mode == 0) begin
            if (req_valid) begin
               m_mode <= req_write ? 1 : 2;
               m_addr <= req_addr;
               m_left <= int'(req_len) + 1;
            end
         end else if (m_beat) begin
            m_addr <= m_addr + 16'd1;
            m_left <= m_left - 1;
            if (m_left == 1) m_mode <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         chk("req_ready", 32'(req_ready), 32'(m_mode == 0));
         chk("busy", 32'(busy), 32'(m_mode != 0));
         chk("wdata_ready", 32'(wdata_ready), 32'(m_mode == 1));
         chk("mem_wren", 32'(mem_wren), 32'((m_mode == 1) && wdata_valid));
         chk("mem_rden", 32'(mem_rden), 32'(m_mode == 2));
         chk("done", 32'(done), 32'(m_done));
         chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
         chk("wren_rden_overlap", 32'(mem_wren && mem_rden), 32'd0);
         if (m_mode != 0) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         if (mem_wren) chk("mem_wdata", 32'(mem_wdata), 32'(wdata));
         if (m_rv) chk("rdata", 32'(rdata), 32'(m_rexp));
      end
   end

   // Plain logs of what the DUT did, used by the hand-computed checks.
   logic [23:0] wr_log[$];
   logic [7:0]  rd_log[$];
   int          rden_cnt = 0;
   int          done_cnt = 0;
   int          rv_at_done = 0;

   always @(negedge clk) begin
      if (rstn) begin
         if (mem_wren) wr_log.push_back({mem_addr, mem_wdata});
         if (rdata_valid) rd_log.push_back(rdata);
         if (mem_rden) rden_cnt++;
         if (done) begin
            done_cnt++;
            if (rdata_valid) rv_at_done++;
         end
      end
   end

   task automatic clear_logs();
      wr_log.delete();
      rd_log.delete();
      rden_cnt = 0;
      done_cnt = 0;
      rv_at_done = 0;
   endtask

   task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] l);
      logic ok;
      ok = 1'b0;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("req_accepted", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("rst_mem_cmd", {30'd0, mem_wren, mem_rden}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Four-beat write, data back-to-back.
      clear_logs();
      do_req(1'b1, 16'h0010, 8'd3);
      for (int i = 0; i < 4; i++) begin
         wdata_valid = 1'b1;
         wdata = 8'hA1 + 8'(i);
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;
      @(negedge clk);
      chk("w21_done_after_beat4", 32'(done), 32'd1);
      chk("w21_beats", 32'(wr_log.size()), 32'd4);
      for (int i = 0; i < wr_log.size() && i < 4; i++)
         chk("w21_addr_data", 32'(wr_log[i]), 32'({16'h0010 + 16'(i), 8'hA1 + 8'(i)}));
      @(posedge clk);
      #1;

      // Read the same four beats back.
      clear_logs();
      do_req(1'b0, 16'h0010, 8'd3);
      wait_done(20);
      chk("r22_rden_cycles", 32'(rden_cnt), 32'd4);
      chk("r22_beats", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < rd_log.size() && i < 4; i++)
         chk("r22_data", 32'(rd_log[i]), 32'(8'hA1 + 8'(i)));
      chk("r22_done_with_last_rv", 32'(rv_at_done), 32'd1);

      // Write across the top of the address space with gapped data.
      clear_logs();
      do_req(1'b1, 16'hFFFE, 8'd3);
      for (int i = 0; i < 7; i++) begin
         wdata_valid = (i % 2 == 0);
         wdata = 8'hB0 + 8'(i);
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;
      @(negedge clk);
      chk("w23_done_cycle8", 32'(done), 32'd1);
      chk("w23_beats", 32'(wr_log.size()), 32'd4);
      if (wr_log.size() == 4) begin
         chk("w23_b0", 32'(wr_log[0]), 32'h00FFFEB0);
         chk("w23_b1", 32'(wr_log[1]), 32'h00FFFFB2);
         chk("w23_b2", 32'(wr_log[2]), 32'h000000B4);
         chk("w23_b3", 32'(wr_log[3]), 32'h000001B6);
      end
      @(posedge clk);
      #1;

      // Single-beat read, with a write request already waiting for the done cycle.
      clear_logs();
      do_req(1'b0, 16'h0010, 8'd0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0200;
      req_len   = 8'd0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("r24_done", 32'(done), 32'd1);
      chk("r24_accept_in_done", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wdata_valid = 1'b1;
      wdata = 8'hC3;
      @(posedge clk);
      #1;
      wdata_valid = 1'b0;
      @(negedge clk);
      chk("r24_write_done", 32'(done), 32'd1);
      chk("r24_rd_beats", 32'(rd_log.size()), 32'd1);
      if (rd_log.size() == 1) chk("r24_rdata", 32'(rd_log[0]), 32'h000000A1);
      chk("r24_wr_beats", 32'(wr_log.size()), 32'd1);
      if (wr_log.size() == 1) chk("r24_wr", 32'(wr_log[0]), 32'h000200C3);
      @(posedge clk);
      #1;

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         req_valid   = ($urandom_range(0, 3) == 0);
         req_write   = 1'($urandom);
         req_addr    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                  : 16'($urandom);
         req_len     = 8'($urandom_range(0, 5));
         wdata_valid = 1'($urandom);
         wdata       = 8'($urandom);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      wdata_valid = 1'b1;
      for (int c = 0; c < 50 && busy; c++) begin
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;
      chk("rand_quiesced", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Maximum-length read, wrapping past 0xFFFF.
      clear_logs();
      do_req(1'b0, 16'hFF80, 8'd255);
      wait_done(400);
      chk("max_len_rden", 32'(rden_cnt), 32'd256);
      chk("max_len_rv", 32'(rd_log.size()), 32'd256);

      // Reset during the second beat of an eight-beat write.
      clear_logs();
      do_req(1'b1, 16'h0300, 8'd7);
      wdata_valid = 1'b1;
      wdata = 8'hD1;
      @(posedge clk);
      #1;
      wdata = 8'hD2;
      #1;
      rstn = 1'b0;
      #1;
      chk("r25_busy", 32'(busy), 32'd0);
      chk("r25_mem_cmd", {30'd0, mem_wren, mem_rden}, 32'd0);
      chk("r25_req_ready", 32'(req_ready), 32'd1);
      chk("r25_mem_addr", 32'(mem_addr), 32'd0);
      wdata_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("r25_done_in_reset", 32'(done), 32'd0);
      chk("r25_rv_in_reset", 32'(rdata_valid), 32'd0);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      @(negedge clk);
      chk("r25_ready_after", 32'(req_ready), 32'd1);
      chk("r25_no_done", 32'(done_cnt), 32'd0);
      chk("r25_beats", 32'(wr_log.size()), 32'd1);
      if (wr_log.size() == 1) chk("r25_beat1", 32'(wr_log[0]), 32'h000300D1);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/burst_ctrl.md
BURST_CTRL -- requirements
Module: burst_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 16, memory address width; DATA_WIDTH, default 8, beat data width; LEN_WIDTH, default 8, burst-length field width.
REQ-002 Reset SHALL be rstn, asynchronous, active-low; clock SHALL be clk.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock
 rstn  in  1  async active-low reset
 req_valid  in  1  burst request present
 req_ready  out  1  controller can accept request
 req_write  in  1  1 = write burst, 0 = read burst
 req_addr  in  ADDR_WIDTH  start address
 req_len  in  LEN_WIDTH  beats minus one (0 = 1 beat)
 wdata_valid  in  1  write beat present
 wdata_ready  out  1  write beat accepted when valid
 wdata  in  DATA_WIDTH  write beat data
 rdata_valid  out  1  read beat valid (no backpressure)
 rdata  out  DATA_WIDTH  read beat data
 busy  out  1  burst in progress
 done  out  1  one-cycle burst-complete pulse
 mem_wren  out  1  memory write enable
 mem_rden  out  1  memory read enable
 mem_addr  out  ADDR_WIDTH  memory address
 mem_wdata  out  DATA_WIDTH  memory write data
 mem_rdata  in  DATA_WIDTH  memory read data, registered, valid one cycle after mem_rden

Function
REQ-004 FSM states SHALL be IDLE, WR, RD; request accepted when req_valid && req_ready; req_ready = 1 only in IDLE.
REQ-005 On acceptance, controller SHALL latch req_addr into address register, req_len into beat counter, and go to WR (req_write=1) or RD (req_write=0).
REQ-006 In WR: wdata_ready = 1; mem_wren = wdata_valid; mem_wdata = wdata; mem_addr = address register; mem_rden = 0.
REQ-007 In WR, each accepted beat SHALL increment address by 1 and decrement counter; beat with counter = 0 SHALL return FSM to IDLE; no beat accepted -> state, address, counter unchanged.
REQ-008 In RD: mem_rden = 1 every cycle, mem_wren = 0, wdata_ready = 0; address increments and counter decrements each cycle; counter = 0 beat returns to IDLE.
REQ-009 rdata_valid SHALL be mem_rden delayed by one register stage; rdata = mem_rdata (combinational pass-through); read latency from mem_rden to rdata_valid = 1 cycle.
REQ-010 Address SHALL increment modulo 2**ADDR_WIDTH (0xFFFF + 1 -> 0x0000 at default) with no error.
REQ-011 done SHALL be a registered pulse asserted exactly one cycle after final mem_wren or final mem_rden, i.e. coincident with last rdata_valid for reads.
REQ-012 busy SHALL be 1 in WR and RD, 0 in IDLE.
REQ-013 Back-to-back: new request SHALL be acceptable in the cycle done is high; outstanding rdata_valid of previous read SHALL still be delivered.
REQ-014 req_len = 2**LEN_WIDTH-1 SHALL produce 2**LEN_WIDTH beats; 1-beat bursts SHALL take one command cycle.
REQ-015 mem_wren and mem_rden SHALL never be asserted together.
REQ-016 Inputs other than wdata/wdata_valid SHALL be ignored while busy.

Reset
REQ-017 Reset SHALL force IDLE; req_ready = 1; wdata_ready, rdata_valid, busy, done, mem_wren, mem_rden = 0; mem_addr, address register, counter = 0.
REQ-018 Reset mid-burst SHALL abort immediately with no further memory command and no done pulse.

Structure
REQ-019 Package burst_pkg SHALL hold the FSM state enum (IDLE, WR, RD) and default width constants.
REQ-020 Block SHALL be a single module with no sub-modules; intended pairing is with the team's single-port registered-read SRAM (mem_* to wren/rden/addr/wr_data/rd_data).

Verification
REQ-021 Write req addr=0x0010 len=3, wdata 0xA1..0xA4 back-to-back -> mem_wren 4 cycles, addrs 0x0010..0x0013, done one cycle after 4th beat.
REQ-022 Read req addr=0x0010 len=3 after REQ-021 -> mem_rden 4 cycles, rdata_valid 0xA1..0xA4 one cycle later, done with 4th rdata_valid.
REQ-023 Write addr=0xFFFE len=3 with wdata_valid toggling 1/0 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 only on valid cycles; 7 cycles total.
REQ-024 Read len=0 then write request held in done cycle -> 1 rdata_valid, write accepted same cycle as done, no wren/rden overlap.
REQ-025 rstn low during beat 2 of len=7 write -> outputs at reset values next edge, no done, req_ready = 1 after release.
